// File: rtl/operator_unit_pipelined.sv
// operator_unit_pipelined: 2-stage valid/ready operator unit covering every operator class, with a saturating op counter
module operator_unit_pipelined #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               flag,
  output logic [COUNT_W-1:0] op_count
);
  localparam int SW = $clog2(WIDTH);
  localparam int HW = WIDTH / 2;
  logic               s1_valid_q, s2_valid_q, flag_q, flag_d, s1_en, s2_en;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, res_q, res_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]     sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic [SW-1:0]      sh;
  assign s2_en     = !s2_valid_q | out_ready;
  assign s1_en     = !s1_valid_q | s2_en;
  assign in_ready  = s1_en & !reset;
  assign out_valid = s2_valid_q;
  assign result    = res_q;
  assign flag      = flag_q;
  assign op_count  = cnt_q;
  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};
  assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign sh   = b_q[SW-1:0];
  always_comb begin
    res_d  = '0;
    flag_d = 1'b0;
    case (op_q)
      4'h0: begin res_d = sum[WIDTH-1:0]; flag_d = sum[WIDTH]; end
      4'h1: begin res_d = diff[WIDTH-1:0]; flag_d = a_q < b_q; end
      4'h2: begin res_d = prod[WIDTH-1:0]; flag_d = |prod[2*WIDTH-1:WIDTH]; end
      4'h3: begin res_d = {{(WIDTH-1){1'b0}}, |a_q && |b_q}; flag_d = res_d[0]; end
      4'h4: begin res_d = {{(WIDTH-1){1'b0}}, |a_q || |b_q}; flag_d = res_d[0]; end
      4'h5: begin res_d = (a_q > b_q) ? a_q : b_q; flag_d = a_q > b_q; end
      4'h6: begin res_d = {{(WIDTH-1){1'b0}}, a_q < b_q}; flag_d = res_d[0]; end
      4'h7: begin res_d = {{(WIDTH-1){1'b0}}, a_q == b_q}; flag_d = a_q != b_q; end
      4'h8: begin res_d = a_q & b_q; flag_d = ~|res_d; end
      4'h9: begin res_d = a_q | b_q; flag_d = ~|res_d; end
      4'hA: begin res_d = a_q ^ b_q; flag_d = ~|res_d; end
      4'hB: begin res_d = ~a_q; flag_d = ~|res_d; end
      4'hC: begin res_d = {{(WIDTH-3){1'b0}}, ^a_q, |a_q, &a_q}; flag_d = ~|a_q; end
      4'hD: begin res_d = a_q << sh; flag_d = ~|res_d; end
      4'hE: begin res_d = a_q >> sh; flag_d = ~|res_d; end
      default: begin res_d = {a_q[HW-1:0], b_q[HW-1:0]}; flag_d = 1'b0; end
    endcase
  end
  // counter saturates at all-ones rather than wrapping
  assign cnt_d = (s2_valid_q & out_ready & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      flag_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (s1_en) begin
        s1_valid_q <= in_valid;
        op_q       <= opcode;
        a_q        <= operand_a;
        b_q        <= operand_b;
      end
      if (s2_en) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          res_q  <= res_d;
          flag_q <= flag_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_operator_unit_pipelined.sv
// tb_operator_unit_pipelined: directed vector table, backpressure, random streaming and reset-in-flight checks
module tb_operator_unit_pipelined;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, flag;
  logic [3:0]  opcode = '0;
  logic [7:0]  operand_a = '0, operand_b = '0, result;
  logic [15:0] op_count;
  int          ncmp = 0, nerr = 0;

  typedef struct {logic [3:0] op; logic [7:0] a, b, r; logic f;} vec_t;
  vec_t v[20];

  operator_unit_pipelined #(.WIDTH(8), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag(flag), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int s;
    int sh;
    logic [7:0] r;
    logic f;
    sh = int'(b) % 8;
    r = '0;
    f = 1'b0;
    case (op)
      4'h0: begin s = int'(a) + int'(b); r = s[7:0]; f = s > 255; end
      4'h1: begin s = int'(a) - int'(b); r = s[7:0]; f = int'(a) < int'(b); end
      4'h2: begin s = int'(a) * int'(b); r = s[7:0]; f = s > 255; end
      4'h3: begin r = (a != 0 && b != 0) ? 8'd1 : 8'd0; f = r[0]; end
      4'h4: begin r = (a != 0 || b != 0) ? 8'd1 : 8'd0; f = r[0]; end
      4'h5: begin r = (int'(a) > int'(b)) ? a : b; f = int'(a) > int'(b); end
      4'h6: begin r = (int'(a) < int'(b)) ? 8'd1 : 8'd0; f = r[0]; end
      4'h7: begin r = (a == b) ? 8'd1 : 8'd0; f = !r[0]; end
      4'h8: begin r = a & b; f = r == 0; end
      4'h9: begin r = a | b; f = r == 0; end
      4'hA: begin r = a ^ b; f = r == 0; end
      4'hB: begin r = 8'hFF - a; f = r == 0; end
      4'hC: begin r = {5'b0, ^a, a != 0, a == 8'hFF}; f = a == 0; end
      4'hD: begin s = int'(a) * (1 << sh); r = s[7:0]; f = r == 0; end
      4'hE: begin s = int'(a) / (1 << sh); r = s[7:0]; f = r == 0; end
      default: begin r = {a[3:0], b[3:0]}; f = 1'b0; end
    endcase
    return {f, r};
  endfunction

  // all tasks start and end at #1 after a rising edge
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op_count", op_count, 0);
    reset = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t x, input int cnt);
    out_ready = 1'b1;
    in_valid = 1'b1; opcode = x.op; operand_a = x.a; operand_b = x.b;
    #1;
    chk({nm, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "_lat1"}, out_valid, 0);
    @(posedge clk); #1;
    chk({nm, "_lat2"}, out_valid, 1);
    chk({nm, "_result"}, result, x.r);
    chk({nm, "_flag"}, flag, x.f);
    @(posedge clk); #1;
    chk({nm, "_count"}, op_count, cnt);
  endtask

  initial begin
    logic [8:0] q[$];
    logic [8:0] e;
    logic [7:0] pr;
    logic pf, stall;
    int sent, got;
    v[0]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 1'b1};
    v[1]  = '{4'h1, 8'h03, 8'h05, 8'hFE, 1'b1};
    v[2]  = '{4'h2, 8'h10, 8'h10, 8'h00, 1'b1};
    v[3]  = '{4'h5, 8'h7F, 8'h80, 8'h80, 1'b0};
    v[4]  = '{4'hD, 8'h01, 8'h0B, 8'h08, 1'b0};
    v[5]  = '{4'hC, 8'h07, 8'h00, 8'h06, 1'b0};
    v[6]  = '{4'hF, 8'hAB, 8'hCD, 8'hBD, 1'b0};
    v[7]  = '{4'h3, 8'h05, 8'h00, 8'h00, 1'b0};
    v[8]  = '{4'h4, 8'h00, 8'h03, 8'h01, 1'b1};
    v[9]  = '{4'h6, 8'h02, 8'h03, 8'h01, 1'b1};
    v[10] = '{4'h7, 8'h44, 8'h44, 8'h01, 1'b0};
    v[11] = '{4'h8, 8'hF0, 8'h0F, 8'h00, 1'b1};
    v[12] = '{4'h9, 8'hF0, 8'h0F, 8'hFF, 1'b0};
    v[13] = '{4'hA, 8'hAA, 8'hAA, 8'h00, 1'b1};
    v[14] = '{4'hB, 8'h00, 8'h00, 8'hFF, 1'b0};
    v[15] = '{4'hE, 8'h80, 8'h0F, 8'h01, 1'b0};
    v[16] = '{4'hC, 8'h00, 8'h00, 8'h00, 1'b1};
    v[17] = '{4'hC, 8'hFF, 8'h00, 8'h03, 1'b0};
    v[18] = '{4'h0, 8'h01, 8'h02, 8'h03, 1'b0};
    v[19] = '{4'h7, 8'h12, 8'h34, 8'h00, 1'b1};
    @(posedge clk); #1;
    do_reset();
    chk("rst_result", result, 0);
    chk("rst_flag", flag, 0);
    for (int i = 0; i < 20; i++) run_vec($sformatf("vec%0d", i), v[i], i + 1);

    // backpressure: two beats fill the pipe, third is held
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; opcode = 4'h0; operand_a = 8'h01; operand_b = 8'h01;
    #1; chk("bp_ready0", in_ready, 1);
    @(posedge clk); #1;
    opcode = 4'h1; operand_a = 8'h10; operand_b = 8'h01;
    chk("bp_ready1", in_ready, 1);
    @(posedge clk); #1;
    opcode = 4'h9; operand_a = 8'h30; operand_b = 8'h03;
    chk("bp_ready2", in_ready, 0);
    @(posedge clk); #1;
    chk("bp_held_ready", in_ready, 0);
    chk("bp_valid0", out_valid, 1);
    chk("bp_res0", result, 8'h02);
    out_ready = 1'b1;
    #1; chk("bp_ready_release", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_valid1", out_valid, 1);
    chk("bp_res1", result, 8'h0F);
    @(posedge clk); #1;
    chk("bp_valid2", out_valid, 1);
    chk("bp_res2", result, 8'h33);
    @(posedge clk); #1;
    chk("bp_empty", out_valid, 0);
    chk("bp_count", op_count, 3);

    // random streaming against the model with random backpressure
    do_reset();
    sent = 0; got = 0; stall = 1'b0; pr = '0; pf = 1'b0;
    for (int cyc = 0; cyc < 5000 && got < 100; cyc++) begin
      in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
      opcode = 4'($urandom_range(0, 15));
      operand_a = 8'($urandom);
      operand_b = 8'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
      #1;
      if (stall) begin
        chk("stall_result", result, pr);
        chk("stall_flag", flag, pf);
      end
      if (in_valid && in_ready) begin
        q.push_back(model(opcode, operand_a, operand_b));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("stream_spurious", 1, 0);
        else begin
          e = q.pop_front();
          chk("stream_result", result, e[7:0]);
          chk("stream_flag", flag, e[8]);
        end
        got++;
      end
      stall = out_valid && !out_ready;
      pr = result;
      pf = flag;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_done", got, 100);
    chk("stream_count", op_count, 100);

    // reset with two ops in flight discards them
    out_ready = 1'b0;
    in_valid = 1'b1; opcode = 4'h0; operand_a = 8'h01; operand_b = 8'h01;
    @(posedge clk); #1;
    operand_a = 8'h02;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight_full", out_valid, 1);
    do_reset();
    run_vec("post_rst", '{4'h0, 8'h0F, 8'h01, 8'h10, 1'b0}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
